// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI receive deserializer.
package spi_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RECV = 1'b1
   } spi_state_e;

   localparam int SPI_WORD_W = 16;

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer with a configurable reset value.
module sync_bit #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_r;

   // shift the asynchronous input through the synchronizer chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= {STAGES{RST_VAL}};
      end else begin
         sync_r <= {sync_r[STAGES-2:0], d};
      end
   end

   assign q = sync_r[STAGES-1];

endmodule

// File: rtl/spi_rx.sv
// SPI receive deserializer: synchronizes CS/SCLK/SDO, assembles MSB-first words.
// Optional SPI_RX_FRAME_CHECK_EN adds FRAME_ERR for truncated frames.
module spi_rx
   import spi_pkg::*;
#(
   parameter int WIDTH       = SPI_WORD_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic             CLK_IN,
   input  logic             RST_N,
   input  logic             EN,
   input  logic             CS,
   input  logic             SCLK,
   input  logic             SDO,
   output logic [WIDTH-1:0] DATA,
   output logic             VALID,
   input  logic             ACK,
   output logic             BUSY,
   output logic             OVERRUN
`ifdef SPI_RX_FRAME_CHECK_EN
   ,
   output logic             FRAME_ERR
`endif
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   spi_state_e       state_r;
   logic [CW-1:0]    cnt_r;
   logic [CW-1:0]    cnt_adv_s;
   logic [WIDTH-1:0] shift_r;
   logic [WIDTH-1:0] word_s;
   logic             cs_sync_s;
   logic             sclk_sync_s;
   logic             sdo_sync_s;
   logic             cs_prev_r;
   logic             sclk_prev_r;
   logic             en_prev_r;
   logic             sclk_rise_s;
   logic             cs_fall_s;
   logic             cs_rise_s;
   logic             last_s;
   logic             start_s;
   logic             complete_s;

   // identical depth on all three lines keeps SDO aligned with SCLK
   sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(CLK_IN), .rst_n(RST_N), .d(CS), .q(cs_sync_s)
   );
   sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(CLK_IN), .rst_n(RST_N), .d(SCLK), .q(sclk_sync_s)
   );
   sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdo (
      .clk(CLK_IN), .rst_n(RST_N), .d(SDO), .q(sdo_sync_s)
   );

   assign sclk_rise_s = sclk_sync_s & ~sclk_prev_r;
   assign cs_fall_s   = ~cs_sync_s & cs_prev_r;
   assign cs_rise_s   = cs_sync_s & ~cs_prev_r;
   assign word_s      = {shift_r[WIDTH-2:0], sdo_sync_s};
   assign last_s      = (cnt_r == CNT_LAST);
   assign cnt_adv_s   = !sclk_rise_s ? cnt_r : (last_s ? CNT_ZERO : cnt_r + CNT_ONE);
   assign start_s     = EN & (cs_fall_s | (~en_prev_r & ~cs_sync_s));
   assign complete_s  = (state_r == RECV) & EN & sclk_rise_s & last_s;

   // receive FSM, word assembly and output handshake
   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         state_r     <= IDLE;
         cnt_r       <= CNT_ZERO;
         shift_r     <= {WIDTH{1'b0}};
         cs_prev_r   <= 1'b1;
         sclk_prev_r <= 1'b0;
         en_prev_r   <= 1'b0;
         DATA        <= {WIDTH{1'b0}};
         VALID       <= 1'b0;
         BUSY        <= 1'b0;
         OVERRUN     <= 1'b0;
`ifdef SPI_RX_FRAME_CHECK_EN
         FRAME_ERR   <= 1'b0;
`endif
      end else begin
         cs_prev_r   <= cs_sync_s;
         sclk_prev_r <= sclk_sync_s;
         en_prev_r   <= EN;
         BUSY        <= (state_r == RECV);
         OVERRUN     <= 1'b0;
`ifdef SPI_RX_FRAME_CHECK_EN
         FRAME_ERR   <= 1'b0;
`endif
         case (state_r)
            IDLE: begin
               if (start_s) begin
                  state_r <= RECV;
                  cnt_r   <= CNT_ZERO;
                  shift_r <= {WIDTH{1'b0}};
               end else begin
                  state_r <= IDLE;
               end
            end
            RECV: begin
               if (!EN) begin
                  state_r <= IDLE;
`ifdef SPI_RX_FRAME_CHECK_EN
                  FRAME_ERR <= (cnt_r != CNT_ZERO);
`endif
               end else begin
                  if (sclk_rise_s) begin
                     shift_r <= word_s;
                     cnt_r   <= cnt_adv_s;
                  end
                  // a final bit coinciding with cs_rise still completes
                  if (cs_rise_s) begin
                     state_r <= IDLE;
`ifdef SPI_RX_FRAME_CHECK_EN
                     FRAME_ERR <= (cnt_adv_s != CNT_ZERO);
`endif
                  end
               end
            end
            default: state_r <= IDLE;
         endcase

         if (complete_s) begin
            if (!VALID || ACK) begin
               DATA  <= word_s;
               VALID <= 1'b1;
            end else begin
               OVERRUN <= 1'b1;
            end
         end else if (ACK && VALID) begin
            VALID <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_rx.sv
// Randomized self-checking bench for spi_rx against a word-level reference model.
module tb_spi_rx;

   localparam int W = 16;

   logic         CLK_IN = 1'b0;
   logic         RST_N  = 1'b0;
   logic         EN     = 1'b0;
   logic         CS     = 1'b1;
   logic         SCLK   = 1'b0;
   logic         SDO    = 1'b0;
   logic         ACK    = 1'b0;
   logic [W-1:0] DATA;
   logic         VALID;
   logic         BUSY;
   logic         OVERRUN;
`ifdef SPI_RX_FRAME_CHECK_EN
   logic         FRAME_ERR;
`endif

   spi_rx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
      .CLK_IN(CLK_IN), .RST_N(RST_N), .EN(EN), .CS(CS), .SCLK(SCLK), .SDO(SDO),
      .DATA(DATA), .VALID(VALID), .ACK(ACK), .BUSY(BUSY), .OVERRUN(OVERRUN)
`ifdef SPI_RX_FRAME_CHECK_EN
      , .FRAME_ERR(FRAME_ERR)
`endif
   );

   always #5 CLK_IN = ~CLK_IN;

   int checks   = 0;
   int failures = 0;

   // event counters, single writer each
   int ovr_cnt  = 0;
   int busy_cnt = 0;
   int ferr_cnt = 0;
   always @(posedge CLK_IN) begin
      if (OVERRUN) ovr_cnt <= ovr_cnt + 1;
      if (BUSY) busy_cnt <= busy_cnt + 1;
`ifdef SPI_RX_FRAME_CHECK_EN
      if (FRAME_ERR) ferr_cnt <= ferr_cnt + 1;
`endif
   end

   // reference model: word-level behaviour of the consumer interface
   logic         m_valid = 1'b0;
   logic [W-1:0] m_data  = '0;
   int           m_ovr   = 0;
   int           m_ferr  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK_IN);
   endtask

   task automatic send_bit(input logic b);
      SDO  = b;
      SCLK = 1'b0;
      tick(3);
      SCLK = 1'b1;
      tick(3);
      SCLK = 1'b0;
   endtask

   task automatic model_word(input logic [W-1:0] w);
      if (!m_valid) begin
         m_valid = 1'b1;
         m_data  = w;
      end else begin
         m_ovr++;
      end
   endtask

   task automatic send_word(input logic [W-1:0] w);
      for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
      tick(2);
      if (EN) model_word(w);
   endtask

   task automatic compare_out(input string tag);
      check({tag, "_valid"}, {31'd0, VALID}, {31'd0, m_valid});
      check({tag, "_data"}, {16'd0, DATA}, {16'd0, m_data});
      check({tag, "_ovr"}, ovr_cnt, m_ovr);
   endtask

   task automatic do_ack();
      ACK = 1'b1;
      tick(1);
      ACK = 1'b0;
      m_valid = 1'b0;
   endtask

   task automatic frame_begin();
      CS = 1'b0;
      tick(4);
   endtask

   task automatic frame_end();
      tick(3);
      CS = 1'b1;
      tick(6);
   endtask

   initial begin
      logic [W-1:0] w;
      int nwords;
      int busy0;

      tick(3);
      check("reset_data", {16'd0, DATA}, 32'd0);
      check("reset_valid", {31'd0, VALID}, 32'd0);
      check("reset_busy", {31'd0, BUSY}, 32'd0);
      check("reset_ovr", {31'd0, OVERRUN}, 32'd0);
      RST_N = 1'b1;
      EN    = 1'b1;
      tick(3);

      // single word
      frame_begin();
      check("busy_in_frame", {31'd0, BUSY}, 32'd1);
      send_word(16'hA5C3);
      frame_end();
      compare_out("single");
      check("single_data_abs", {16'd0, DATA}, 32'h0000A5C3);
      do_ack();
      check("ack_clears", {31'd0, VALID}, 32'd0);

      // back-to-back in one frame with acks
      frame_begin();
      send_word(16'h1234);
      compare_out("b2b_first");
      do_ack();
      send_word(16'hBEEF);
      compare_out("b2b_second");
      do_ack();
      frame_end();

      // overrun
      frame_begin();
      send_word(16'h00FF);
      send_word(16'hFF00);
      frame_end();
      compare_out("overrun");
      check("overrun_keep_first", {16'd0, DATA}, 32'h000000FF);
      do_ack();

      // truncated frame then a full word
      frame_begin();
      for (int i = 15; i >= 7; i--) send_bit(1'b1);
      frame_end();
`ifdef SPI_RX_FRAME_CHECK_EN
      m_ferr++;
`endif
      check("trunc_ferr", ferr_cnt, m_ferr);
      compare_out("trunc");
      frame_begin();
      send_word(16'h5A5A);
      frame_end();
      compare_out("after_trunc");
      do_ack();

      // reset mid-frame
      frame_begin();
      for (int i = 0; i < 8; i++) send_bit(i[0]);
      RST_N = 1'b0;
      CS    = 1'b1;
      tick(2);
      check("rst_mid_data", {16'd0, DATA}, 32'd0);
      check("rst_mid_valid", {31'd0, VALID}, 32'd0);
      check("rst_mid_busy", {31'd0, BUSY}, 32'd0);
      m_valid = 1'b0;
      m_data  = '0;
      RST_N = 1'b1;
      tick(3);
      frame_begin();
      send_word(16'h0F0F);
      frame_end();
      compare_out("after_rst");
      do_ack();

      // EN low during traffic
      EN = 1'b0;
      tick(2);
      busy0 = busy_cnt;
      frame_begin();
      send_word(16'hC0DE);
      frame_end();
      check("en_low_busy", busy_cnt - busy0, 0);
      compare_out("en_low");
      EN = 1'b1;
      tick(3);

      // randomized frames
      for (int f = 0; f < 20; f++) begin
         nwords = $urandom_range(1, 3);
         frame_begin();
         for (int k = 0; k < nwords; k++) begin
            w = W'($urandom);
            send_word(w);
            compare_out("rand");
            if ($urandom_range(0, 1) == 1) begin
               do_ack();
               check("rand_ack", {31'd0, VALID}, 32'd0);
            end
         end
         frame_end();
      end
      check("final_ferr", ferr_cnt, m_ferr);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
